// File: rtl/dma_io_peripheral.sv
// DMA device endpoint: local FIFO, DREQ/DACK handshake, transfer commits on strobe rising edge.
// DONE and FIFO update land one cycle after strobe rise; DREQ drops when FIFO cannot serve.
module dma_io_peripheral #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LENWIDTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic                          DIR,
  input  logic [LENWIDTH-1:0]           BLOCK_LEN,
  output logic                          DREQ,
  input  logic                          DACK,
  input  logic                          IOR_N,
  input  logic                          IOW_N,
  input  logic                          EOP_N_IN,
  output logic                          EOP_N_OUT,
  output logic                          EOP_OE,
  input  logic [DATAWIDTH-1:0]          DB_IN,
  output logic [DATAWIDTH-1:0]          DB_OUT,
  output logic                          DB_OE,
  input  logic                          LOC_WR_EN,
  input  logic [DATAWIDTH-1:0]          LOC_WR_DATA,
  input  logic                          LOC_RD_EN,
  output logic [DATAWIDTH-1:0]          LOC_RD_DATA,
  output logic                          LOC_FULL,
  output logic                          LOC_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          OVF_ERR,
  output logic                          UNF_ERR
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = LENWIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_STROBE} state_t;

  state_t               state;
  logic                 dir_q, busy_q, done_q, ovf_q, unf_q, eop_pend, strb_low_q;
  logic [RW-1:0]        remaining;
  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [DATAWIDTH-1:0] db_q;

  logic strobe_n, empty, full, ready, commit, last, eop_now, end_blk;
  logic bus_pop, bus_push, push_req, pop_req, do_push, do_pop;
  logic [DATAWIDTH-1:0] push_dat;

  // Only the strobe matching the latched direction is ever looked at.
  assign strobe_n = dir_q ? IOW_N : IOR_N;
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign ready    = dir_q ? ~full : ~empty;
  assign commit   = (state == S_STROBE) && strobe_n && strb_low_q;
  assign last     = (remaining == RW'(1));
  assign eop_now  = ~EOP_N_IN & DACK & ~EOP_OE & busy_q;
  assign end_blk  = eop_now | eop_pend;

  assign bus_pop  = commit & ~dir_q;
  assign bus_push = commit & dir_q;
  assign push_req = bus_push | LOC_WR_EN;
  assign pop_req  = bus_pop | LOC_RD_EN;
  assign do_pop   = pop_req & ~empty;
  assign do_push  = push_req & (~full | do_pop);
  assign push_dat = bus_push ? db_q : LOC_WR_DATA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      db_q       <= '0;
      strb_low_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      strb_low_q <= ~strobe_n;
      if (!IOW_N && DACK) db_q <= DB_IN;
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
      if (push_req && full && !do_pop) ovf_q <= 1'b1;
      if (bus_pop && empty)            unf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      remaining <= '0;
      eop_pend  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (START) begin
          busy_q    <= 1'b1;
          dir_q     <= DIR;
          remaining <= (BLOCK_LEN == '0) ? {1'b1, {LENWIDTH{1'b0}}} : {1'b0, BLOCK_LEN};
          eop_pend  <= 1'b0;
          state     <= S_REQ;
        end
        S_REQ: begin
          if (end_blk) begin
            state <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b1; remaining <= '0; eop_pend <= 1'b0;
          end else if (DACK) state <= S_ACK;
        end
        S_ACK: begin
          if (!strobe_n) begin
            state <= S_STROBE;
            if (eop_now) eop_pend <= 1'b1;
          end else if (end_blk) begin
            state <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b1; remaining <= '0; eop_pend <= 1'b0;
          end else if (!DACK) state <= S_REQ;
        end
        S_STROBE: begin
          if (eop_now) eop_pend <= 1'b1;
          if (commit) begin
            remaining <= remaining - RW'(1);
            if (last || end_blk) begin
              state <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b1; remaining <= '0; eop_pend <= 1'b0;
            end else state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Empty-FIFO bus read presents all-ones while the strobe is in progress.
  assign DB_OUT      = empty ? ((state == S_STROBE && !dir_q) ? '1 : '0) : mem[rd_ptr];
  assign DB_OE       = ~dir_q & DACK & ~IOR_N & ((state == S_ACK) || (state == S_STROBE));
  assign DREQ        = ((state == S_REQ) && ready) || (state == S_ACK) || (state == S_STROBE);
  assign EOP_OE      = (state == S_STROBE) && last;
  assign EOP_N_OUT   = 1'b0;
  assign LOC_RD_DATA = mem[rd_ptr];
  assign LOC_FULL    = full;
  assign LOC_EMPTY   = empty;
  assign FIFO_COUNT  = count;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign OVF_ERR     = ovf_q;
  assign UNF_ERR     = unf_q;
endmodule
